// File: rtl/emulib_pkg.sv
// Shared types and helpers for the emulib burst FIFO read side.
package emulib_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DROP   = 2'd2
    } state_e;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/emulib_skid_buffer.sv
// Two-entry registered skid stage; both ready and valid come straight from flops.
module emulib_skid_buffer #(
    parameter int WIDTH = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic             push, pop;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_q;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head always holds the oldest entry; tail is only used while two are held.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) head_d = in_data;
                else                 tail_d = in_data;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                head_d = in_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule

// File: rtl/emulib_burst_reader.sv
// Store-and-forward burst reader: pops a burst only when it is complete in the FIFO,
// forwards it through a skid stage or discards it, and reports length/status per burst.
module emulib_burst_reader
    import emulib_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter int MAX_LEN = 256,
    parameter int CNTW    = $clog2(DEPTH),
    parameter int LENW    = len_width(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    input  logic [CNTW:0]    s_bursts,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    input  logic             drop,
    output logic             busy,
    output logic             done,
    output logic [LENW-1:0]  done_len,
    output logic             done_dropped,
    output logic             err_long
);

    localparam logic [LENW-1:0] MAX_CNT = LENW'(MAX_LEN);

    state_e          state_q, state_d;
    logic            drop_pending_q, drop_pending_d;
    logic [LENW-1:0] cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [LENW-1:0] done_len_q, done_len_d;
    logic            done_dropped_q, done_dropped_d;
    logic            err_long_q, err_long_d;

    logic            skid_in_valid, skid_in_ready, skid_out_valid;
    logic [WIDTH:0]  skid_out;
    logic            s_hs;

    assign s_ready       = ((state_q == STREAM) && skid_in_ready) || (state_q == DROP);
    assign s_hs          = s_valid && s_ready;
    assign skid_in_valid = s_valid && (state_q == STREAM);

    emulib_skid_buffer #(
        .WIDTH(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (skid_in_valid),
        .in_ready (skid_in_ready),
        .in_data  ({s_last, s_data}),
        .out_valid(skid_out_valid),
        .out_ready(m_ready),
        .out_data (skid_out)
    );

    // Leaving to IDLE after every last beat gives s_bursts a cycle to reflect the pop.
    always_comb begin
        state_d        = state_q;
        drop_pending_d = drop_pending_q || drop;
        cnt_d          = cnt_q;
        done_d         = 1'b0;
        done_len_d     = done_len_q;
        done_dropped_d = done_dropped_q;
        err_long_d     = err_long_q;
        case (state_q)
            IDLE: begin
                if (s_bursts != '0) begin
                    if (drop_pending_q) begin
                        state_d        = DROP;
                        drop_pending_d = drop;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM, DROP: begin
                if (s_hs) begin
                    if (s_last) begin
                        state_d        = IDLE;
                        cnt_d          = '0;
                        done_d         = 1'b1;
                        done_len_d     = (cnt_q == MAX_CNT) ? MAX_CNT : cnt_q + LENW'(1);
                        done_dropped_d = (state_q == DROP);
                    end else if (cnt_q == MAX_CNT) begin
                        err_long_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + LENW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            drop_pending_q <= 1'b0;
            cnt_q          <= '0;
            done_q         <= 1'b0;
            done_len_q     <= '0;
            done_dropped_q <= 1'b0;
            err_long_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_pending_q <= drop_pending_d;
            cnt_q          <= cnt_d;
            done_q         <= done_d;
            done_len_q     <= done_len_d;
            done_dropped_q <= done_dropped_d;
            err_long_q     <= err_long_d;
        end
    end

    assign m_valid      = skid_out_valid;
    assign m_last       = skid_out[WIDTH];
    assign m_data       = skid_out[WIDTH-1:0];
    assign busy         = (state_q != IDLE) || skid_out_valid;
    assign done         = done_q;
    assign done_len     = done_len_q;
    assign done_dropped = done_dropped_q;
    assign err_long     = err_long_q;

endmodule

// File: tb/tb_emulib_burst_reader.sv
// Scoreboard bench for emulib_burst_reader driven by a behavioural burst FIFO model.
module tb_emulib_burst_reader;

    localparam int WIDTH   = 32;
    localparam int DEPTH   = 8;
    localparam int MAX_LEN = 5;
    localparam int CNTW    = $clog2(DEPTH);
    localparam int LENW    = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [CNTW:0]    s_bursts;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             drop;
    logic             busy;
    logic             done;
    logic [LENW-1:0]  done_len;
    logic             done_dropped;
    logic             err_long;

    int             compared   = 0;
    int             mismatched = 0;
    int             cyc        = 0;
    int             first_mv   = -1;
    int             t_start    = 0;
    int             cur_len    = 0;
    bit             rand_ready = 1'b0;
    bit             exp_err    = 1'b0;
    int             pop_cyc[$];
    logic [WIDTH:0] fifo_q[$];
    logic [WIDTH:0] exp_q[$];
    logic [LENW:0]  exp_done_q[$];

    always #5 clk = ~clk;

    emulib_burst_reader #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .s_bursts    (s_bursts),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_data      (m_data),
        .m_last      (m_last),
        .drop        (drop),
        .busy        (busy),
        .done        (done),
        .done_len    (done_len),
        .done_dropped(done_dropped),
        .err_long    (err_long)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic driveFifo();
        int n;
        n = 0;
        foreach (fifo_q[i]) if (fifo_q[i][WIDTH]) n++;
        s_bursts = (CNTW+1)'(n);
        s_valid  = (fifo_q.size() != 0);
        if (fifo_q.size() != 0) {s_last, s_data} = fifo_q[0];
        else                    {s_last, s_data} = '0;
    endtask

    // Loads beats into the FIFO model and records what the DUT must produce for them.
    task automatic applyStimulus(input int nbeats, input bit with_last, input bit dropped);
        logic [WIDTH-1:0] d;
        bit               is_last;
        for (int k = 0; k < nbeats; k++) begin
            d       = $urandom;
            is_last = with_last && (k == nbeats - 1);
            cur_len++;
            if (!is_last && (cur_len - 1 >= MAX_LEN)) exp_err = 1'b1;
            fifo_q.push_back({is_last, d});
            if (!dropped) exp_q.push_back({is_last, d});
            if (is_last) begin
                exp_done_q.push_back({dropped, LENW'(cur_len > MAX_LEN ? MAX_LEN : cur_len)});
                cur_len = 0;
            end
        end
        driveFifo();
    endtask

    task automatic step();
        bit             pop_s;
        logic [WIDTH:0] e;
        logic [LENW:0]  ed;
        @(negedge clk);
        pop_s = s_valid && s_ready;
        if (pop_s) pop_cyc.push_back(cyc);
        if (m_valid && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) checkOutput("beat_sb_empty", exp_q.size(), 1);
            else begin
                e = exp_q.pop_front();
                checkOutput("beat", {m_last, m_data}, e);
            end
        end
        if (done) begin
            if (exp_done_q.size() == 0) checkOutput("done_sb_empty", exp_done_q.size(), 1);
            else begin
                ed = exp_done_q.pop_front();
                checkOutput("done_status", {done_dropped, done_len}, ed);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop_s) void'(fifo_q.pop_front());
        m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        driveFifo();
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || exp_done_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
        end
        checkOutput("drain_left", 64'(fifo_q.size() + exp_q.size() + exp_done_q.size()) + (busy ? 64'd256 : 64'd0), 0);
    endtask

    task automatic startTest();
        pop_cyc.delete();
        first_mv = -1;
        t_start  = cyc;
    endtask

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b1;
        drop    = 1'b0;
        driveFifo();
        #12;
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_m_valid", m_valid, 0);
        checkOutput("rst_m_data", {m_last, m_data}, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", {done, done_dropped, done_len}, 0);
        checkOutput("rst_err_long", err_long, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single 4-beat burst: latency and ordering.
        startTest();
        applyStimulus(4, 1'b1, 1'b0);
        drain(50);
        checkOutput("t1_first_mvalid", first_mv, t_start + 2);
        checkOutput("t1_pops", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4) checkOutput("t1_first_pop", pop_cyc[0], t_start + 1);

        // Back-to-back 3-beat bursts need exactly one idle cycle between them.
        startTest();
        applyStimulus(3, 1'b1, 1'b0);
        applyStimulus(3, 1'b1, 1'b0);
        drain(50);
        checkOutput("t2_pops", pop_cyc.size(), 6);
        if (pop_cyc.size() == 6) begin
            checkOutput("t2_in_burst_rate", pop_cyc[2] - pop_cyc[0], 2);
            checkOutput("t2_gap", pop_cyc[3] - pop_cyc[2], 2);
        end

        // Incomplete burst must not be popped.
        startTest();
        applyStimulus(2, 1'b0, 1'b0);
        repeat (4) begin
            step();
            checkOutput("t3_s_ready", s_ready, 0);
            checkOutput("t3_m_valid", m_valid, 0);
        end
        applyStimulus(1, 1'b1, 1'b0);
        drain(50);

        // Two drop pulses collapse into one; next burst dropped, the following one forwarded.
        startTest();
        drop = 1'b1;
        step();
        step();
        drop = 1'b0;
        step();
        checkOutput("t4_busy_idle", busy, 0);
        startTest();
        applyStimulus(5, 1'b1, 1'b1);
        drain(50);
        checkOutput("t4_no_mvalid", first_mv, -1);
        checkOutput("t4_pops", pop_cyc.size(), 5);
        if (pop_cyc.size() == 5) checkOutput("t4_pop_span", pop_cyc[4] - pop_cyc[0], 4);
        applyStimulus(2, 1'b1, 1'b0);
        drain(50);

        // Drop arriving mid-stream applies to the next burst only.
        applyStimulus(3, 1'b1, 1'b0);
        step();
        step();
        drop = 1'b1;
        step();
        drop = 1'b0;
        applyStimulus(2, 1'b1, 1'b1);
        drain(50);

        // Length boundary: MAX_LEN+1 beats saturates without error; one more sets err_long.
        applyStimulus(MAX_LEN + 1, 1'b1, 1'b0);
        drain(50);
        checkOutput("t5_err_boundary", err_long, exp_err);
        applyStimulus(MAX_LEN + 2, 1'b1, 1'b0);
        drain(50);
        checkOutput("t5_err_set", err_long, exp_err);
        applyStimulus(2, 1'b1, 1'b0);
        drain(50);
        checkOutput("t5_err_sticky", err_long, exp_err);

        // Random backpressure on an 8-beat burst.
        rand_ready = 1'b1;
        applyStimulus(8, 1'b1, 1'b0);
        drain(300);
        rand_ready = 1'b0;
        m_ready    = 1'b1;

        // Reset in the middle of a burst.
        startTest();
        applyStimulus(6, 1'b1, 1'b0);
        repeat (3) step();
        checkOutput("t7_mid_m_valid", m_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t7_rst_m_valid", m_valid, 0);
        checkOutput("t7_rst_busy", busy, 0);
        checkOutput("t7_rst_err_long", err_long, 0);
        fifo_q.delete();
        exp_q.delete();
        exp_done_q.delete();
        exp_err = 1'b0;
        cur_len = 0;
        driveFifo();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(3, 1'b1, 1'b0);
        drain(50);
        checkOutput("t7_err_after", err_long, exp_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
